// File: rtl/jk_bank_pkg.sv
// rtl/jk_bank_pkg.sv - op codes, JK pair constants and FSM state type for the JK bank controller
package jk_bank_pkg;

  typedef enum logic [2:0] {
    OP_NOP        = 3'b000,
    OP_CLEAR      = 3'b001,
    OP_LOAD       = 3'b010,
    OP_TOGGLE     = 3'b011,
    OP_COUNT_UP   = 3'b100,
    OP_COUNT_DOWN = 3'b101,
    OP_SHIFT_L    = 3'b110,
    OP_ROTATE_R   = 3'b111
  } op_t;

  // {j, k} pairs
  localparam logic [1:0] JK_HOLD = 2'b00;
  localparam logic [1:0] JK_RST  = 2'b01;
  localparam logic [1:0] JK_SET  = 2'b10;
  localparam logic [1:0] JK_TGL  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_DONE
  } state_t;

  // Ops with the MSB set run for cmd_len steps; the rest are single-step.
  function automatic logic is_multi(op_t op);
    return op[2];
  endfunction

endpackage

// File: rtl/jk_bank_controller_if.sv
// rtl/jk_bank_controller_if.sv - command handshake and status bundle for the JK bank controller
interface jk_bank_controller_if
  import jk_bank_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  op_t              cmd_op;
  logic [WIDTH-1:0] cmd_arg;
  logic [CNT_W-1:0] cmd_len;
  logic             abort;
  logic             busy;
  logic             done;
  logic             aborted;

  modport master (
    output cmd_valid, cmd_op, cmd_arg, cmd_len, abort,
    input  cmd_ready, busy, done, aborted
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_arg, cmd_len, abort,
    output cmd_ready, busy, done, aborted
  );
endinterface

// File: rtl/jk_bank_controller_step_decode.sv
// rtl/jk_bank_controller_step_decode.sv - combinational (op, arg, q) -> (j, k) for one bank step
module jk_step_decode
  import jk_bank_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  op_t              op,
  input  logic [WIDTH-1:0] arg,
  input  logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k
);

  logic [WIDTH-1:0] up_tgl;
  logic [WIDTH-1:0] dn_tgl;
  logic [WIDTH-1:0] shl;
  logic [WIDTH-1:0] ror;
  logic [1:0]       pair;

  // A bit toggles when every lower bit is 1 (up) or 0 (down).
  always_comb begin
    up_tgl    = '0;
    dn_tgl    = '0;
    up_tgl[0] = 1'b1;
    dn_tgl[0] = 1'b1;
    for (int i = 1; i < WIDTH; i++) begin
      up_tgl[i] = up_tgl[i-1] & q[i-1];
      dn_tgl[i] = dn_tgl[i-1] & ~q[i-1];
    end
  end

  assign shl = {q[WIDTH-2:0], arg[0]};
  assign ror = {q[0], q[WIDTH-1:1]};

  always_comb begin
    j    = '0;
    k    = '0;
    pair = JK_HOLD;
    for (int i = 0; i < WIDTH; i++) begin
      case (op)
        OP_NOP:        pair = JK_HOLD;
        OP_CLEAR:      pair = JK_RST;
        OP_LOAD:       pair = arg[i]    ? JK_SET : JK_RST;
        OP_TOGGLE:     pair = arg[i]    ? JK_TGL : JK_HOLD;
        OP_COUNT_UP:   pair = up_tgl[i] ? JK_TGL : JK_HOLD;
        OP_COUNT_DOWN: pair = dn_tgl[i] ? JK_TGL : JK_HOLD;
        OP_SHIFT_L:    pair = shl[i]    ? JK_SET : JK_RST;
        OP_ROTATE_R:   pair = ror[i]    ? JK_SET : JK_RST;
        default:       pair = JK_HOLD;
      endcase
      j[i] = pair[1];
      k[i] = pair[0];
    end
  end

endmodule

// File: rtl/jk_ff.sv
// rtl/jk_ff.sv - single JK flip-flop cell of the bank
module jk_ff (
  input  logic clk,
  input  logic rst,
  input  logic j,
  input  logic k,
  output logic q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= 1'b0;
    end else begin
      case ({j, k})
        2'b01:   q <= 1'b0;
        2'b10:   q <= 1'b1;
        2'b11:   q <= ~q;
        default: q <= q;
      endcase
    end
  end

endmodule

// File: rtl/jk_bank_controller.sv
// rtl/jk_bank_controller.sv - command sequencer driving per-bit J/K vectors of a JK flip-flop bank
module jk_bank_controller
  import jk_bank_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  jk_bank_controller_if.slave  bus,
  input  logic [WIDTH-1:0]     q_in,
  output logic [WIDTH-1:0]     j_out,
  output logic [WIDTH-1:0]     k_out
);

  state_t           state;
  state_t           nxt;
  logic [CNT_W-1:0] cnt;
  op_t              op_q;
  logic [WIDTH-1:0] arg_q;
  logic             ab_q;
  logic [WIDTH-1:0] dec_j;
  logic [WIDTH-1:0] dec_k;
  logic             step_en;

  jk_step_decode #(.WIDTH(WIDTH)) u_decode (
    .op  (op_q),
    .arg (arg_q),
    .q   (q_in),
    .j   (dec_j),
    .k   (dec_k)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      op_q  <= OP_NOP;
      arg_q <= '0;
      ab_q  <= 1'b0;
    end else begin
      state <= nxt;
      case (state)
        ST_IDLE: begin
          if (bus.cmd_valid) begin
            op_q  <= bus.cmd_op;
            arg_q <= bus.cmd_arg;
            cnt   <= is_multi(bus.cmd_op) ? bus.cmd_len : CNT_W'(1);
            ab_q  <= 1'b0;
          end
        end
        ST_EXEC: begin
          cnt <= cnt - CNT_W'(1);
          if (bus.abort) ab_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          if (is_multi(bus.cmd_op) && (bus.cmd_len == '0)) nxt = ST_DONE;
          else                                             nxt = ST_EXEC;
        end
      end
      // Abort takes priority over the last step, so it is checked first.
      ST_EXEC: begin
        if (bus.abort || (cnt == CNT_W'(1))) nxt = ST_DONE;
      end
      ST_DONE: nxt = ST_IDLE;
      default: nxt = ST_IDLE;
    endcase
  end

  assign step_en       = (state == ST_EXEC) && !bus.abort;
  assign j_out         = step_en ? dec_j : '0;
  assign k_out         = step_en ? dec_k : '0;
  assign bus.cmd_ready = (state == ST_IDLE);
  assign bus.busy      = (state == ST_EXEC);
  assign bus.done      = (state == ST_DONE);
  assign bus.aborted   = (state == ST_DONE) && ab_q;

endmodule
